// File: rtl/boo_scan_pkg.sv
// Shared types and helpers for the truth-table scanner.
package boo_scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSample,
    StEmit,
    StDone
  } state_e;

  // Truth-table width for an n-input function.
  function automatic int unsigned tt_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/boo_scan_ctr.sv
// Settle-time counter and combination index for the scanner sweep.
module boo_scan_ctr #(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            settle_en_i,
  input  logic            idx_inc_i,
  output logic [N_IN-1:0] idx_o,
  output logic            settle_done_o,
  output logic            last_idx_o
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [SW-1:0]   settle_q, settle_d;
  logic [N_IN-1:0] idx_q, idx_d;

  assign idx_o         = idx_q;
  assign settle_done_o = settle_en_i && (settle_q == SW'(SETTLE_CYC - 1));
  assign last_idx_o    = (idx_q == {N_IN{1'b1}});

  // Settle count restarts whenever the drive phase ends; index saturates at the last combination.
  always_comb begin
    settle_d = '0;
    if (settle_en_i && !settle_done_o) begin
      settle_d = settle_q + SW'(1);
    end
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (idx_inc_i && !last_idx_o) begin
      idx_d = idx_q + N_IN'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      idx_q    <= '0;
    end else begin
      settle_q <= settle_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/boo_truth_table_scanner.sv
// Sweeps all input combinations of a combinational FUT, records its truth table
// and streams out every combination whose output equals the requested target.
module boo_truth_table_scanner
  import boo_scan_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    target,
  output logic [N_IN-1:0]         fut_in,
  input  logic                    fut_out,
  output logic                    match_valid,
  input  logic                    match_ready,
  output logic [N_IN-1:0]         match_vec,
  output logic [tt_w(N_IN)-1:0]   truth_table,
  output logic [N_IN:0]           match_count,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned TtW = tt_w(N_IN);
  localparam int unsigned CntW = N_IN + 1;

  state_e          state_q, state_d;
  logic [TtW-1:0]  tt_q, tt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            target_q, target_d;

  logic            ctr_clr, settle_en, idx_inc;
  logic [N_IN-1:0] idx;
  logic            settle_done, last_idx;

  boo_scan_ctr #(
    .N_IN       (N_IN),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_ctr (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (ctr_clr),
    .settle_en_i   (settle_en),
    .idx_inc_i     (idx_inc),
    .idx_o         (idx),
    .settle_done_o (settle_done),
    .last_idx_o    (last_idx)
  );

  assign fut_in      = idx;
  assign match_vec   = vec_q;
  assign truth_table = tt_q;
  assign match_count = cnt_q;
  assign match_valid = (state_q == StEmit);
  assign busy        = (state_q == StDrive) || (state_q == StSample) || (state_q == StEmit);
  assign done        = (state_q == StDone);

  // Sweep sequencing and result accumulation.
  always_comb begin
    state_d   = state_q;
    tt_d      = tt_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    target_d  = target_q;
    ctr_clr   = 1'b0;
    settle_en = 1'b0;
    idx_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDrive;
          tt_d     = '0;
          cnt_d    = '0;
          target_d = target;
          ctr_clr  = 1'b1;
        end
      end
      StDrive: begin
        settle_en = 1'b1;
        if (settle_done) begin
          state_d = StSample;
        end
      end
      StSample: begin
        tt_d[idx] = fut_out;
        if (fut_out == target_q) begin
          cnt_d   = cnt_q + CntW'(1);
          vec_d   = idx;
          state_d = StEmit;
        end else if (last_idx) begin
          state_d = StDone;
        end else begin
          idx_inc = 1'b1;
          state_d = StDrive;
        end
      end
      StEmit: begin
        if (match_ready) begin
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_inc = 1'b1;
            state_d = StDrive;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tt_q     <= '0;
      cnt_q    <= '0;
      vec_q    <= '0;
      target_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tt_q     <= tt_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_boo_truth_table_scanner.sv
// Directed bench for boo_truth_table_scanner using FUT y = a'b' + c'.
module tb_boo_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       target = 1'b0;
  logic       match_ready = 1'b1;
  logic [2:0] fut_in;
  logic       fut_out;
  logic       match_valid;
  logic [2:0] match_vec;
  logic [7:0] truth_table;
  logic [3:0] match_count;
  logic       busy;
  logic       done;

  // Second instance: longer settle time with a registered FUT.
  logic       start6 = 1'b0;
  logic [2:0] fut_in6;
  logic       fut_out6;
  logic       match_valid6;
  logic [2:0] match_vec6;
  logic [7:0] truth_table6;
  logic [3:0] match_count6;
  logic       busy6;
  logic       done6;
  logic       fut_d1 = 1'b0;
  logic       fut_d2 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_pulses = 0;
  int pulse_base = 0;
  int done6_cyc = 0;
  int done6_pulses = 0;
  logic [2:0] vecs[$];
  int exp_q[$];

  always #5 clk = ~clk;

  assign fut_out = (~fut_in[2] & ~fut_in[1]) | ~fut_in[0];

  always @(posedge clk) begin
    fut_d1 <= (~fut_in6[2] & ~fut_in6[1]) | ~fut_in6[0];
    fut_d2 <= fut_d1;
  end
  assign fut_out6 = fut_d2;

  always @(posedge clk) cyc <= cyc + 1;

  // Record transfers and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (match_valid && match_ready) vecs.push_back(match_vec);
    if (done) begin
      done_pulses <= done_pulses + 1;
      done_cyc    <= cyc;
    end
    if (done6) begin
      done6_pulses <= done6_pulses + 1;
      done6_cyc    <= cyc;
    end
  end

  boo_truth_table_scanner #(
    .N_IN       (3),
    .SETTLE_CYC (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target      (target),
    .fut_in      (fut_in),
    .fut_out     (fut_out),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .match_vec   (match_vec),
    .truth_table (truth_table),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  boo_truth_table_scanner #(
    .N_IN       (3),
    .SETTLE_CYC (3)
  ) dut6 (
    .clk         (clk),
    .rst         (rst),
    .start       (start6),
    .target      (1'b1),
    .fut_in      (fut_in6),
    .fut_out     (fut_out6),
    .match_valid (match_valid6),
    .match_ready (1'b1),
    .match_vec   (match_vec6),
    .truth_table (truth_table6),
    .match_count (match_count6),
    .busy        (busy6),
    .done        (done6)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {9'd0, fut_in, match_valid, match_vec, truth_table, match_count, busy, done}, 32'd0);
  endtask

  task automatic start_sweep(input logic tgt);
    @(posedge clk); #1;
    vecs.delete();
    pulse_base = done_pulses;
    start  = 1'b1;
    target = tgt;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("fut_in_first", fut_in, 0);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #2;
      if (done_pulses != pulse_base) seen = 1'b1;
    end
    check_eq("done_seen", 32'(seen), 1);
  endtask

  task automatic check_sweep(input int exp_lat, input int exp_cnt);
    check_eq("latency", done_cyc - start_cyc, exp_lat);
    check_eq("truth_table", truth_table, 32'h57);
    check_eq("match_count", match_count, exp_cnt);
    check_eq("n_vectors", vecs.size(), exp_q.size());
    foreach (exp_q[i]) begin
      check_eq("vector", (i < vecs.size()) ? 32'(vecs[i]) : 32'hdead, exp_q[i]);
    end
    repeat (2) @(posedge clk);
    #2;
    check_eq("single_done", done_pulses - pulse_base, 1);
    check_eq("busy_idle", busy, 0);
    check_eq("fut_in_hold", fut_in, 7);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: target=1, ready tied high.
    exp_q = '{0, 1, 2, 4, 6};
    start_sweep(1'b1);
    wait_done(200);
    check_sweep(21, 5);

    // 2: target=0.
    exp_q = '{3, 5, 7};
    start_sweep(1'b0);
    wait_done(200);
    check_sweep(19, 3);

    // 3: backpressure for 10 cycles on the first match.
    exp_q = '{0, 1, 2, 4, 6};
    match_ready = 1'b0;
    start_sweep(1'b1);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(posedge clk); #2;
        if (match_valid) got = 1'b1;
      end
      check_eq("first_valid", 32'(got), 1);
    end
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_valid", match_valid, 1);
      check_eq("stall_vec", match_vec, 0);
      @(posedge clk); #1;
    end
    match_ready = 1'b1;
    wait_done(200);
    check_sweep(31, 5);

    // 4: restart attempt and target toggle mid-sweep are ignored.
    exp_q = '{0, 1, 2, 4, 6};
    start_sweep(1'b1);
    repeat (4) @(posedge clk);
    #1;
    start  = 1'b1;
    target = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    check_sweep(21, 5);

    // 5: asynchronous reset while vector 2 is being offered.
    start_sweep(1'b1);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(posedge clk); #2;
        if (match_valid && match_vec == 3'd2) got = 1'b1;
      end
      check_eq("emit_vec2", 32'(got), 1);
    end
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #2;
    check_eq("no_done_on_reset", done_pulses - pulse_base, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q = '{0, 1, 2, 4, 6};
    start_sweep(1'b1);
    wait_done(200);
    check_sweep(21, 5);

    // 6: SETTLE_CYC=3 instance with a 2-cycle registered FUT.
    begin
      int s6;
      int base6;
      bit got = 1'b0;
      @(posedge clk); #1;
      base6  = done6_pulses;
      start6 = 1'b1;
      @(posedge clk); #1;
      s6     = cyc;
      start6 = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(posedge clk); #2;
        if (done6_pulses != base6) got = 1'b1;
      end
      check_eq("s6_done_seen", 32'(got), 1);
      check_eq("s6_latency", done6_cyc - s6, 37);
      check_eq("s6_truth_table", truth_table6, 32'h57);
      check_eq("s6_match_count", match_count6, 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
